// File: rtl/dcache_req_adapter.sv
// Simple request adapter between a valid/ready upstream port and a CVA6-style
// dcache request port. At most one request is outstanding at a time. Loads
// follow the index-then-tag protocol; stores send index and tag together.
// A cycle counter aborts requests that the cache never grants or never
// answers.

// Minimal dcache port definitions. Only the fields this adapter drives or
// consumes are present. The struct field widths are taken from the package
// constants, so IDX_W and TAG_W must match them.
package ariane_pkg;
  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;
endpackage

module dcache_req_adapter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned IDX_W   = ariane_pkg::DCACHE_INDEX_WIDTH,
  parameter int unsigned TAG_W   = ariane_pkg::DCACHE_TAG_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [TAG_W+IDX_W-1:0]    req_addr_i,
  input  logic                      req_we_i,
  input  logic [63:0]               req_wdata_i,
  input  logic [7:0]                req_be_i,
  input  logic [1:0]                req_size_i,
  output logic                      resp_valid_o,
  output logic [63:0]               resp_data_o,
  output logic                      resp_err_o,
  output ariane_pkg::dcache_req_i_t dcache_req_o,
  input  ariane_pkg::dcache_req_o_t dcache_resp_i,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    TAG     = 2'd2,
    WAIT_RV = 2'd3
  } state_e;

  // Last counter value allowed before an abort; the counter starts at 0 in
  // the first REQ cycle, so TIMEOUT cycles are spent in REQ/TAG/WAIT_RV.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  ariane_pkg::dcache_req_i_t dreq_q, dreq_d;
  logic                      resp_valid_q, resp_valid_d;
  logic                      resp_err_q, resp_err_d;
  logic [63:0]               resp_data_q, resp_data_d;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dreq_d           = dreq_q;
    dreq_d.kill_req  = 1'b0;
    resp_valid_d     = 1'b0;
    resp_err_d       = 1'b0;
    resp_data_d      = resp_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d              = REQ;
          cnt_d                = 16'd0;
          dreq_d.data_req      = 1'b1;
          dreq_d.address_index = req_addr_i[IDX_W-1:0];
          dreq_d.address_tag   = req_addr_i[TAG_W+IDX_W-1:IDX_W];
          dreq_d.data_we       = req_we_i;
          dreq_d.data_wdata    = req_wdata_i;
          dreq_d.data_be       = req_be_i;
          dreq_d.data_size     = req_size_i;
          dreq_d.tag_valid     = req_we_i;
        end
      end

      REQ: begin
        cnt_d = cnt_q + 16'd1;
        if (dcache_resp_i.data_gnt) begin
          dreq_d.data_req = 1'b0;
          if (dreq_q.data_we) begin
            state_d          = IDLE;
            dreq_d.tag_valid = 1'b0;
            resp_valid_d     = 1'b1;
            resp_data_d      = 64'd0;
          end else begin
            state_d          = TAG;
            dreq_d.tag_valid = 1'b1;
          end
        end else if (cnt_q >= CntLast) begin
          state_d          = IDLE;
          dreq_d.data_req  = 1'b0;
          dreq_d.tag_valid = 1'b0;
          resp_valid_d     = 1'b1;
          resp_err_d       = 1'b1;
          resp_data_d      = 64'd0;
        end
      end

      TAG: begin
        cnt_d            = cnt_q + 16'd1;
        dreq_d.tag_valid = 1'b0;
        if (dcache_resp_i.data_rvalid) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = dcache_resp_i.data_rdata;
        end else begin
          state_d = WAIT_RV;
        end
      end

      WAIT_RV: begin
        cnt_d = cnt_q + 16'd1;
        if (dcache_resp_i.data_rvalid) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_data_d  = dcache_resp_i.data_rdata;
        end else if (cnt_q >= CntLast) begin
          state_d         = IDLE;
          dreq_d.kill_req = 1'b1;
          resp_valid_d    = 1'b1;
          resp_err_d      = 1'b1;
          resp_data_d     = 64'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and output registers; reset clears the request lines at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      dreq_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dreq_q       <= dreq_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign dcache_req_o = dreq_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_data_o  = resp_data_q;
  assign req_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_req_adapter.sv
// Self-checking bench for dcache_req_adapter. Expected responses are queued
// when a request is driven and compared when resp_valid_o pulses.
module tb_dcache_req_adapter;

  localparam int unsigned IDX_W = ariane_pkg::DCACHE_INDEX_WIDTH;
  localparam int unsigned TAG_W = ariane_pkg::DCACHE_TAG_WIDTH;

  typedef struct packed {
    logic        err;
    logic [63:0] data;
  } exp_t;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      req_valid_i;
  logic                      req_ready_o;
  logic [TAG_W+IDX_W-1:0]    req_addr_i;
  logic                      req_we_i;
  logic [63:0]               req_wdata_i;
  logic [7:0]                req_be_i;
  logic [1:0]                req_size_i;
  logic                      resp_valid_o;
  logic [63:0]               resp_data_o;
  logic                      resp_err_o;
  ariane_pkg::dcache_req_i_t dreq;
  ariane_pkg::dcache_req_o_t dresp;
  logic                      busy_o;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  dcache_req_adapter #(
    .TIMEOUT(8),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_we_i     (req_we_i),
    .req_wdata_i  (req_wdata_i),
    .req_be_i     (req_be_i),
    .req_size_i   (req_size_i),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .dcache_req_o (dreq),
    .dcache_resp_i(dresp),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Counts a comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_i);
  endtask

  function automatic logic [63:0] bbData(input int i);
    return 64'h0123_4567_89AB_0000 + 64'(i);
  endfunction

  // Scoreboard: every response pulse is matched against the oldest expectation
  always @(negedge clk_i) begin
    if (!rst_i && resp_valid_o) begin
      if (expQ.size() == 0) begin
        checkOutput("stray_resp", 64'(resp_valid_o), 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("resp_err", 64'(resp_err_o), 64'(e.err));
        checkOutput("resp_data", resp_data_o, e.data);
      end
    end
  end

  // Drives one request until it is accepted, then checks the captured fields
  task automatic applyStimulus(input logic we, input logic [TAG_W-1:0] tagv,
                               input logic [IDX_W-1:0] idx, input logic [63:0] wdata,
                               input logic [7:0] be, input logic [1:0] size);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = {tagv, idx};
    req_wdata_i = wdata;
    req_be_i    = be;
    req_size_i  = size;
    tick();
    req_valid_i = 1'b0;
    checkOutput("accept_busy", 64'(busy_o), 64'd1);
    checkOutput("cap_index", 64'(dreq.address_index), 64'(idx));
    checkOutput("cap_we", 64'(dreq.data_we), 64'(we));
    checkOutput("cap_wdata", dreq.data_wdata, wdata);
    checkOutput("cap_be", 64'(dreq.data_be), 64'(be));
    checkOutput("cap_size", 64'(dreq.data_size), 64'(size));
    if (we) checkOutput("cap_tag", 64'(dreq.address_tag), 64'(tagv));
  endtask

  // One transaction with gnt/rvalid pulsed at given cycles (-1 = never);
  // cycle k=0 is the first cycle after acceptance
  task automatic runTxn(input string tag, input logic we, input logic [TAG_W-1:0] tagv,
                        input logic [IDX_W-1:0] idx, input logic [63:0] wdata,
                        input logic [7:0] be, input int gntAt, input int rvAt,
                        input logic [63:0] rdata, input logic expErr,
                        input logic [63:0] expData, input int expRespK,
                        input int expReqCyc, input int expTagCyc, input int expKill);
    int reqCyc, tagCyc, killCyc, respCnt, respK;
    exp_t e;
    reqCyc = 0; tagCyc = 0; killCyc = 0; respCnt = 0; respK = -1;
    e.err  = expErr;
    e.data = expData;
    expQ.push_back(e);
    applyStimulus(we, tagv, idx, wdata, be, 2'd3);
    for (int k = 0; k < 12; k++) begin
      reqCyc  += int'(dreq.data_req);
      tagCyc  += int'(dreq.tag_valid);
      killCyc += int'(dreq.kill_req);
      if (resp_valid_o) begin
        respCnt++;
        respK = k;
        checkOutput({tag, "_kill_with_resp"}, 64'(dreq.kill_req), 64'(expKill != 0));
      end
      dresp.data_gnt    = (k == gntAt);
      dresp.data_rvalid = (k == rvAt);
      dresp.data_rdata  = (k == rvAt) ? rdata : 64'd0;
      tick();
    end
    dresp = '0;
    checkOutput({tag, "_resp_cycle"}, 64'(respK), 64'(expRespK));
    checkOutput({tag, "_resp_count"}, 64'(respCnt), 64'd1);
    checkOutput({tag, "_req_cycles"}, 64'(reqCyc), 64'(expReqCyc));
    checkOutput({tag, "_tag_cycles"}, 64'(tagCyc), 64'(expTagCyc));
    checkOutput({tag, "_kill_cycles"}, 64'(killCyc), 64'(expKill));
  endtask

  // Main sequence
  initial begin
    int   accepted, rdIdx, respCount;
    logic willAccept;
    exp_t e;

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_we_i    = 1'b0;
    req_wdata_i = '0;
    req_be_i    = '0;
    req_size_i  = '0;
    dresp       = '0;
    tick();
    tick();
    checkOutput("rst_dreq", 64'(dreq != '0), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err_o), 64'd0);
    checkOutput("rst_resp_data", resp_data_o, 64'd0);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b0;
    tick();

    $display("[TB] store with delayed gnt and stray rvalid in REQ");
    runTxn("store", 1'b1, 44'h5A, 12'h040, 64'h1122_3344_5566_7788, 8'hFF,
           3, 1, 64'hFFFF_0000_FFFF_0000, 1'b0, 64'd0, 4, 4, 4, 0);

    $display("[TB] load with immediate gnt");
    runTxn("load", 1'b0, 44'h5A, 12'h040, 64'd0, 8'hFF,
           0, 3, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 4, 1, 1, 0);

    $display("[TB] load with rvalid never returned");
    runTxn("ld_tmo", 1'b0, 44'h123, 12'h7FF, 64'd0, 8'h0F,
           0, -1, 64'd0, 1'b1, 64'd0, 8, 1, 1, 1);
    dresp.data_rvalid = 1'b1;
    dresp.data_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    dresp = '0;
    checkOutput("stray_rvalid", 64'(resp_valid_o), 64'd0);
    checkOutput("stray_busy", 64'(busy_o), 64'd0);
    tick();

    $display("[TB] load with gnt never returned");
    runTxn("gnt_tmo", 1'b0, 44'h0, 12'h001, 64'd0, 8'h01,
           -1, -1, 64'd0, 1'b1, 64'd0, 8, 8, 0, 0);

    $display("[TB] gnt and rvalid coinciding with timeout");
    runTxn("gnt_last", 1'b1, 44'hABC, 12'h100, 64'h0F0F_0F0F_0F0F_0F0F, 8'h3C,
           7, -1, 64'd0, 1'b0, 64'd0, 8, 8, 8, 0);
    runTxn("rv_last", 1'b0, 44'hABC, 12'h100, 64'd0, 8'hFF,
           0, 7, 64'h5555_AAAA_5555_AAAA, 1'b0, 64'h5555_AAAA_5555_AAAA, 8, 1, 1, 0);

    $display("[TB] four back-to-back loads");
    for (int i = 0; i < 4; i++) begin
      e.err  = 1'b0;
      e.data = bbData(i);
      expQ.push_back(e);
    end
    accepted    = 0;
    rdIdx       = 0;
    respCount   = 0;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = {44'h77, 12'h0A0};
    for (int c = 0; c < 100 && respCount < 4; c++) begin
      checkOutput("ready_vs_busy", 64'(req_ready_o), 64'(!busy_o));
      if (resp_valid_o) begin
        respCount++;
        checkOutput("resp_while_idle", 64'(busy_o), 64'd0);
      end
      willAccept        = req_valid_i && req_ready_o;
      dresp.data_gnt    = dreq.data_req;
      dresp.data_rvalid = busy_o && !dreq.data_req && !dreq.tag_valid;
      dresp.data_rdata  = bbData(rdIdx);
      if (dresp.data_rvalid) rdIdx++;
      tick();
      if (willAccept) begin
        accepted++;
        if (accepted == 4) req_valid_i = 1'b0;
      end
    end
    dresp = '0;
    checkOutput("bb_resp_count", 64'(respCount), 64'd4);
    checkOutput("bb_accepted", 64'(accepted), 64'd4);
    tick();

    $display("[TB] reset while waiting for rvalid");
    applyStimulus(1'b0, 44'h99, 12'h033, 64'd0, 8'hFF, 2'd3);
    dresp.data_gnt = 1'b1;
    tick();
    dresp.data_gnt = 1'b0;
    tick();
    tick();
    checkOutput("wait_busy", 64'(busy_o), 64'd1);
    #2;
    rst_i = 1'b1;
    #1;
    expQ.delete();
    checkOutput("mid_rst_data_req", 64'(dreq.data_req), 64'd0);
    checkOutput("mid_rst_tag_valid", 64'(dreq.tag_valid), 64'd0);
    checkOutput("mid_rst_kill", 64'(dreq.kill_req), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy_o), 64'd0);
    checkOutput("mid_rst_resp_valid", 64'(resp_valid_o), 64'd0);
    checkOutput("mid_rst_resp_data", resp_data_o, 64'd0);
    tick();
    rst_i = 1'b0;
    runTxn("post_rst", 1'b0, 44'h99, 12'h033, 64'd0, 8'hFF,
           0, 2, 64'h0BAD_F00D_1234_5678, 1'b0, 64'h0BAD_F00D_1234_5678, 3, 1, 1, 0);

    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule

// File: doc/dcache_req_adapter.md
DCACHE_REQ_ADAPTER -- requirements
Module: dcache_req_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the max cycles spent in REQ plus WAIT_RV before abort; legal range 4..65535.
REQ-002 SHALL have parameter IDX_W, default ariane_pkg::DCACHE_INDEX_WIDTH, meaning the cache index width.
REQ-003 SHALL have parameter TAG_W, default ariane_pkg::DCACHE_TAG_WIDTH, meaning the cache tag width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports named per codebase convention.
REQ-005 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid_i, input, 1 bit: upstream request valid.
REQ-008 SHALL have port req_ready_o, output, 1 bit: adapter accepts a request.
REQ-009 SHALL have port req_addr_i, input, TAG_W+IDX_W bits: {tag, index}.
REQ-010 SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-011 SHALL have port req_wdata_i, input, 64 bits: store data.
REQ-012 SHALL have port req_be_i, input, 8 bits: byte enables.
REQ-013 SHALL have port req_size_i, input, 2 bits: access size.
REQ-014 SHALL have port resp_valid_o, output, 1 bit: single-cycle completion pulse.
REQ-015 SHALL have port resp_data_o, output, 64 bits: load data; 0 for stores and errors.
REQ-016 SHALL have port resp_err_o, output, 1 bit: completion was a timeout abort.
REQ-017 SHALL have port dcache_req_o, output, dcache_req_i_t: drives the dcache port.
REQ-018 SHALL have port dcache_resp_i, input, dcache_req_o_t: dcache gnt, rvalid and rdata.
REQ-019 SHALL have port busy_o, output, 1 bit: state != IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, TAG, WAIT_RV; all dcache_req_o fields SHALL be registered outputs.
REQ-021 req_ready_o SHALL equal (state==IDLE); a transfer occurs when req_valid_i && req_ready_o, and IDLE SHALL go to REQ, capturing all req_* fields.
REQ-022 In REQ, the adapter SHALL hold data_req=1, address_index=captured index, data_we, data_wdata, data_be and data_size stable until data_gnt.
REQ-023 For stores in REQ, the adapter SHALL also drive address_tag=captured tag and tag_valid=1.
REQ-024 For loads in REQ, tag_valid SHALL be 0.
REQ-025 On data_gnt in REQ: a store SHALL go to IDLE with resp_valid_o=1 the next cycle; a load SHALL go to TAG.
REQ-026 In TAG, the adapter SHALL drive data_req=0, tag_valid=1 and address_tag for exactly one cycle, then go to WAIT_RV.
REQ-027 data_rvalid in TAG or WAIT_RV SHALL latch data_rdata into resp_data_o, pulse resp_valid_o for one cycle, and return to IDLE.
REQ-028 data_rvalid in IDLE or REQ SHALL be ignored.
REQ-029 A 16-bit cycle counter SHALL clear on entry to REQ and increment in REQ, TAG and WAIT_RV.
REQ-030 If the counter reaches TIMEOUT-1 in REQ without gnt, data_req SHALL drop next cycle, resp_valid_o=resp_err_o=1 for one cycle, and the FSM SHALL go to IDLE.
REQ-031 If the counter reaches TIMEOUT-1 in WAIT_RV, kill_req=1 for one cycle, resp_valid_o=resp_err_o=1, and the FSM SHALL go to IDLE.
REQ-032 gnt or rvalid arriving in the same cycle as the timeout SHALL win: a normal completion with no error.
REQ-033 A response SHALL never coincide with acceptance of the next request: minimum one IDLE cycle between requests, giving one outstanding request max.
REQ-034 kill_req SHALL be 0 except as specified in REQ-031.

Reset
REQ-035 While rst_i=1, the FSM SHALL be IDLE, the counter 0, and all dcache_req_o fields, resp_valid_o, resp_data_o, resp_err_o and busy_o SHALL be 0.
REQ-036 Assertion of rst_i mid-transaction SHALL immediately (asynchronously) deassert data_req and tag_valid, with no kill_req pulse.
REQ-037 The first accept after reset SHALL be possible on the first rising edge with rst_i=0.

Verification
REQ-038 Store addr={tag 0x5A, idx 0x040}, be=0xFF, gnt held 0 for 3 cycles -> data_req high 4 cycles with tag_valid=1; resp_valid_o one cycle after gnt, resp_err_o=0.
REQ-039 Load with gnt the same cycle as data_req, rvalid 2 cycles after TAG, rdata=0xDEADBEEF_CAFEF00D -> tag_valid exactly one cycle; resp_data_o=0xDEADBEEF_CAFEF00D.
REQ-040 TIMEOUT=8, load gnted, rvalid never sent -> kill_req single pulse, resp_err_o=1; a later stray rvalid produces no resp_valid_o.
REQ-041 TIMEOUT=8, gnt never sent -> data_req drops after 8 REQ cycles; resp_err_o=1; kill_req stays 0.
REQ-042 Back-to-back req_valid_i held high for 4 loads -> req_ready_o low whenever busy_o=1; 4 responses in order with no overlap.
REQ-043 rst_i pulsed while in WAIT_RV -> all outputs 0 within the reset cycle; the next load completes normally.
